plant_safety_ctrl: RTL and testbench

Supervisory controller for the monitoring board. It sits between the raw sensors (fire, gas, IR) and the actuators (motor driver IN1/IN2, buzzer, alarm LED). It synchronises and debounces the active-low sensor inputs and runs a latched-alarm state machine: the motor stops on any fault, restarts only after an operator acknowledge and a timed restart delay, and alarm events are counted. It replaces the free-running per-sensor logic with one sequenced owner of the motor and alarm outputs.

---
 rtl/plant_safety_ctrl.sv | 229 ++++++++++++++++++++++
 tb/tb_plant_safety_ctrl.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/plant_safety_ctrl.sv
// Supervisory safety controller: conditions the fire/gas sensors and sequences
// the motor and alarm outputs through a latched-alarm state machine.
module plant_safety_ctrl #(
    parameter int TICK_DIV      = 50000,
    parameter int DEB_TICKS     = 20,
    parameter int RESTART_TICKS = 3000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       fire,
    input  logic       gas_in,
    input  logic       start,
    input  logic       stop,
    input  logic       ack,
    output logic       IN1,
    output logic       IN2,
    output logic       buzzer,
    output logic       led_alarm,
    output logic       led_run,
    output logic [1:0] fault_code,
    output logic [7:0] alarm_count,
    output logic [1:0] state
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DW = (DEB_TICKS > 0) ? $clog2(DEB_TICKS + 1) : 1;
    localparam int RW = (RESTART_TICKS > 0) ? $clog2(RESTART_TICKS + 1) : 1;

    localparam logic [TW-1:0] TICK_LAST    = TW'(TICK_DIV - 1);
    localparam logic [DW-1:0] DEB_LAST     = DW'(DEB_TICKS - 1);
    localparam logic [RW-1:0] RESTART_LAST = RW'(RESTART_TICKS - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RUN     = 2'd1,
        S_ALARM   = 2'd2,
        S_RESTART = 2'd3
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [TW-1:0]   tick_cnt;
    logic            tick;
    logic [1:0]      raw;
    logic [1:0]      sync_a;
    logic [1:0]      sync_b;
    logic [1:0]      filt;
    logic [DW-1:0]   deb_cnt [2];
    logic            fire_f;
    logic            gas_f;
    logic            fault;
    logic [RW-1:0]   restart_cnt;
    logic            restart_done;
    logic            buzz_q;
    logic            entering_alarm;
    logic            leaving_alarm;
    logic [1:0]      active_faults;
    logic [1:0]      fault_q;
    logic [7:0]      count_q;

    assign tick = (tick_cnt == TICK_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    // Bit 0 is fire, bit 1 is gas; synchroniser flops idle at the inactive level.
    assign raw = {gas_in, fire};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_a <= 2'b11;
            sync_b <= 2'b11;
        end else begin
            sync_a <= raw;
            sync_b <= sync_a;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            filt <= 2'b11;
            for (int i = 0; i < 2; i++) begin
                deb_cnt[i] <= '0;
            end
        end else if (tick) begin
            for (int i = 0; i < 2; i++) begin
                if (sync_b[i] != filt[i]) begin
                    if (deb_cnt[i] == DEB_LAST) begin
                        filt[i]    <= sync_b[i];
                        deb_cnt[i] <= '0;
                    end else begin
                        deb_cnt[i] <= deb_cnt[i] + 1'b1;
                    end
                end else begin
                    deb_cnt[i] <= '0;
                end
            end
        end
    end

    assign fire_f        = filt[0];
    assign gas_f         = filt[1];
    assign active_faults = {~gas_f, ~fire_f};
    assign fault         = |active_faults;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Fault always wins, then stop, then start/ack.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (fault) begin
                    state_d = S_ALARM;
                end else if (start && !stop) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (fault) begin
                    state_d = S_ALARM;
                end else if (stop) begin
                    state_d = S_IDLE;
                end
            end
            S_ALARM: begin
                if (ack && !fault) begin
                    state_d = S_RESTART;
                end
            end
            S_RESTART: begin
                if (fault) begin
                    state_d = S_ALARM;
                end else if (stop) begin
                    state_d = S_IDLE;
                end else if (restart_done) begin
                    state_d = S_RUN;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        IN1       = 1'b0;
        led_run   = 1'b0;
        led_alarm = 1'b0;
        buzzer    = 1'b0;
        case (state_q)
            S_RUN: begin
                IN1     = 1'b1;
                led_run = 1'b1;
            end
            S_ALARM: begin
                led_alarm = 1'b1;
                buzzer    = buzz_q;
            end
            default: begin
                IN1 = 1'b0;
            end
        endcase
    end

    assign IN2   = 1'b0;
    assign state = state_q;

    // Held at zero outside RESTART so every entry starts a fresh delay.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            restart_cnt <= '0;
        end else if (state_q != S_RESTART) begin
            restart_cnt <= '0;
        end else if (tick) begin
            restart_cnt <= restart_cnt + 1'b1;
        end
    end

    assign restart_done = tick && (restart_cnt == RESTART_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            buzz_q <= 1'b0;
        end else if (state_q != S_ALARM) begin
            buzz_q <= 1'b0;
        end else if (tick) begin
            buzz_q <= ~buzz_q;
        end
    end

    assign entering_alarm = (state_d == S_ALARM) && (state_q != S_ALARM);
    assign leaving_alarm  = (state_q == S_ALARM) && (state_d != S_ALARM);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fault_q <= 2'b00;
        end else if (entering_alarm) begin
            fault_q <= active_faults;
        end else if (leaving_alarm) begin
            fault_q <= 2'b00;
        end else if (state_q == S_ALARM) begin
            fault_q <= fault_q | active_faults;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= 8'd0;
        end else if (entering_alarm && (count_q != 8'hFF)) begin
            count_q <= count_q + 8'd1;
        end
    end

    assign fault_code  = fault_q;
    assign alarm_count = count_q;

endmodule

// File: tb/tb_plant_safety_ctrl.sv
// Directed bench for plant_safety_ctrl: a vector table for the start/stop/ack
// sequencing plus hand-written sensor, restart and saturation sequences.
module tb_plant_safety_ctrl;

    logic       clk;
    logic       reset;
    logic       fire;
    logic       gas_in;
    logic       start;
    logic       stop;
    logic       ack;
    logic       IN1;
    logic       IN2;
    logic       buzzer;
    logic       led_alarm;
    logic       led_run;
    logic [1:0] fault_code;
    logic [7:0] alarm_count;
    logic [1:0] state;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       start;
        logic       stop;
        logic       ack;
        logic [1:0] state;
        logic       in1;
        logic       run;
        string      name;
    } vec_t;

    vec_t vecs [12];

    plant_safety_ctrl #(
        .TICK_DIV(4),
        .DEB_TICKS(3),
        .RESTART_TICKS(5)
    ) dut (
        .clk(clk),
        .reset(reset),
        .fire(fire),
        .gas_in(gas_in),
        .start(start),
        .stop(stop),
        .ack(ack),
        .IN1(IN1),
        .IN2(IN2),
        .buzzer(buzzer),
        .led_alarm(led_alarm),
        .led_run(led_run),
        .fault_code(fault_code),
        .alarm_count(alarm_count),
        .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic wait_state(input logic [1:0] target, input int budget, output int cycles);
        cycles = 0;
        while (state !== target && cycles < budget) begin
            cycle();
            cycles++;
        end
        if (state !== target) begin
            checks++;
            errors++;
            $display("[TB] FAIL wait_state: got %0d, expected %0d within %0d clk", state, target, budget);
        end
    endtask

    task automatic apply_stimulus(input logic s, input logic p, input logic a);
        start = s;
        stop  = p;
        ack   = a;
        cycle();
        start = 1'b0;
        stop  = 1'b0;
        ack   = 1'b0;
    endtask

    task automatic measure_toggle(output int gap);
        logic prev;
        prev = buzzer;
        gap  = 0;
        while (buzzer === prev && gap < 10) begin
            cycle();
            gap++;
        end
    endtask

    task automatic check_output_zero(input string tag);
        check($sformatf("%s.state", tag), state, 0);
        check($sformatf("%s.IN1", tag), IN1, 0);
        check($sformatf("%s.IN2", tag), IN2, 0);
        check($sformatf("%s.buzzer", tag), buzzer, 0);
        check($sformatf("%s.led_alarm", tag), led_alarm, 0);
        check($sformatf("%s.led_run", tag), led_run, 0);
        check($sformatf("%s.fault_code", tag), fault_code, 0);
        check($sformatf("%s.alarm_count", tag), alarm_count, 0);
    endtask

    initial begin
        int cyc;
        int gap;
        int not_run;

        vecs[0]  = '{1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, "idle_hold"};
        vecs[1]  = '{1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, "idle_start_stop"};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, "idle_stop"};
        vecs[3]  = '{1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, "idle_ack"};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 2'd1, 1'b1, 1'b1, "idle_start"};
        vecs[5]  = '{1'b1, 1'b0, 1'b0, 2'd1, 1'b1, 1'b1, "run_start"};
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 2'd1, 1'b1, 1'b1, "run_ack"};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, "run_stop"};
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 2'd1, 1'b1, 1'b1, "start_again"};
        vecs[9]  = '{1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, "run_start_stop"};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, "idle_hold2"};
        vecs[11] = '{1'b1, 1'b0, 1'b0, 2'd1, 1'b1, 1'b1, "start_final"};

        reset  = 1'b0;
        fire   = 1'b1;
        gas_in = 1'b1;
        start  = 1'b0;
        stop   = 1'b0;
        ack    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_output_zero("reset");
        @(negedge clk);
        reset = 1'b1;
        cycle();

        for (int i = 0; i < 12; i++) begin
            apply_stimulus(vecs[i].start, vecs[i].stop, vecs[i].ack);
            check($sformatf("%s.state", vecs[i].name), state, vecs[i].state);
            check($sformatf("%s.IN1", vecs[i].name), IN1, vecs[i].in1);
            check($sformatf("%s.led_run", vecs[i].name), led_run, vecs[i].run);
            check($sformatf("%s.led_alarm", vecs[i].name), led_alarm, 0);
            check($sformatf("%s.IN2", vecs[i].name), IN2, 0);
        end

        // Fire in RUN: 2 sync clocks plus 3 debounce ticks, then one edge to ALARM.
        fire = 1'b0;
        wait_state(2'd2, 30, cyc);
        check_range("fire_latency", cyc, 12, 15);
        check("fire.IN1", IN1, 0);
        check("fire.led_alarm", led_alarm, 1);
        check("fire.led_run", led_run, 0);
        check("fire.fault_code", fault_code, 1);
        check("fire.alarm_count", alarm_count, 1);
        measure_toggle(gap);
        measure_toggle(gap);
        check("buzzer_period1", gap, 4);
        measure_toggle(gap);
        check("buzzer_period2", gap, 4);

        apply_stimulus(1'b0, 1'b0, 1'b1);
        check("ack_with_fault.state", state, 2);
        check("ack_with_fault.fault_code", fault_code, 1);
        apply_stimulus(1'b0, 1'b1, 1'b0);
        check("stop_in_alarm.state", state, 2);

        fire = 1'b1;
        repeat (16) cycle();
        check("fire_cleared.state", state, 2);
        apply_stimulus(1'b0, 1'b0, 1'b1);
        check("ack_clear.state", state, 3);
        check("ack_clear.fault_code", fault_code, 0);
        check("ack_clear.buzzer", buzzer, 0);
        check("ack_clear.IN1", IN1, 0);
        wait_state(2'd1, 30, cyc);
        check_range("restart_delay", cyc, 17, 20);
        check("restart_run.IN1", IN1, 1);

        // A gas glitch of two ticks never reaches the debounce threshold.
        gas_in = 1'b0;
        repeat (8) cycle();
        gas_in  = 1'b1;
        not_run = 0;
        for (int i = 0; i < 24; i++) begin
            cycle();
            if (state !== 2'd1) not_run++;
        end
        check("glitch.cycles_not_run", not_run, 0);
        check("glitch.alarm_count", alarm_count, 1);

        fire = 1'b0;
        wait_state(2'd2, 30, cyc);
        check("alarm2.alarm_count", alarm_count, 2);
        fire = 1'b1;
        repeat (16) cycle();
        apply_stimulus(1'b0, 1'b0, 1'b1);
        check("alarm2_ack.state", state, 3);
        apply_stimulus(1'b0, 1'b1, 1'b0);
        check("stop_in_restart.state", state, 0);

        apply_stimulus(1'b1, 1'b0, 1'b0);
        check("run3.state", state, 1);
        fire = 1'b0;
        wait_state(2'd2, 30, cyc);
        fire = 1'b1;
        repeat (16) cycle();
        apply_stimulus(1'b0, 1'b0, 1'b1);
        check("alarm3_ack.state", state, 3);
        gas_in = 1'b0;
        wait_state(2'd2, 30, cyc);
        check_range("gas_in_restart_latency", cyc, 12, 15);
        check("gas_restart.fault_code", fault_code, 2);
        check("gas_restart.alarm_count", alarm_count, 4);
        fire = 1'b0;
        repeat (20) cycle();
        check("fault_or_in.fault_code", fault_code, 3);
        check("fault_or_in.alarm_count", alarm_count, 4);
        fire   = 1'b1;
        gas_in = 1'b1;
        repeat (16) cycle();
        apply_stimulus(1'b0, 1'b0, 1'b1);
        check("both_cleared.state", state, 3);
        check("both_cleared.fault_code", fault_code, 0);

        // 252 more episodes bring the total to 256 alarm entries.
        for (int i = 0; i < 252; i++) begin
            fire = 1'b0;
            wait_state(2'd2, 30, cyc);
            fire = 1'b1;
            repeat (16) cycle();
            apply_stimulus(1'b0, 1'b0, 1'b1);
        end
        check("saturate.alarm_count", alarm_count, 255);
        check("saturate.state", state, 3);

        repeat (3) cycle();
        check("pre_reset.state", state, 3);
        #2;
        reset = 1'b0;
        #1;
        check_output_zero("async_reset");
        @(negedge clk);
        reset = 1'b1;
        cycle();
        apply_stimulus(1'b1, 1'b0, 1'b0);
        check("post_reset_start.state", state, 1);
        check("post_reset_start.IN1", IN1, 1);
        check("post_reset_start.alarm_count", alarm_count, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
